// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: RISC-V load/store funct3 codes,
// FSM state encodings and the alignment check.
package mem_stage_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  typedef enum logic [1:0] {
    MemIdle,
    MemReq,
    MemWait
  } mem_state_e;

  // Undefined funct3 values decode as word accesses, so they need word alignment.
  function automatic logic is_misaligned(logic [2:0] func3, logic [1:0] addr);
    return ((func3[1:0] == 2'b01) && addr[0]) || (func3[1] && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign/zero-extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (func3)
      FNC_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      FNC_LBU: data = {24'b0, byte_sel};
      FNC_LH:  data = {{16{half_sel[15]}}, half_sel};
      FNC_LHU: data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: executes loads/stores over a req/gnt/rvalid port and
// registers the writeback bundle; stalls upstream while an access is in flight.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_alu_out,
  input  logic [DWIDTH-1:0] in_store_data,
  input  logic [2:0]        in_func3,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic              in_csr_rd,
  input  logic [DWIDTH-1:0] in_csr_data,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_we,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DWIDTH-1:0] wb_data,
  output logic              misalign
);

  mem_state_e        state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        func3_q, func3_d;
  logic              is_store_q, is_store_d;
  logic              reg_we_q, reg_we_d;
  logic              mem_req_d;
  logic [3:0]        mem_we_d;
  logic [AWIDTH-1:0] mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_d;
  logic              wb_valid_d, wb_we_d, misalign_d;
  logic [4:0]        wb_rd_d;
  logic [DWIDTH-1:0] wb_data_d;
  logic [3:0]        st_we;
  logic [DWIDTH-1:0] st_wdata;
  logic [DWIDTH-1:0] load_val;

  assign in_ready = (state_q == MemIdle);

  mem_stage_load_align u_load_align (
    .rdata (mem_rdata),
    .addr  (addr_lo_q),
    .func3 (func3_q),
    .data  (load_val)
  );

  always_comb begin
    case (in_func3)
      FNC_SB: begin
        st_we    = 4'b0001 << in_alu_out[1:0];
        st_wdata = {4{in_store_data[7:0]}};
      end
      FNC_SH: begin
        st_we    = 4'b0011 << {in_alu_out[1], 1'b0};
        st_wdata = {2{in_store_data[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = in_store_data;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    func3_d     = func3_q;
    is_store_d  = is_store_q;
    reg_we_d    = reg_we_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wb_valid_d  = 1'b0;
    misalign_d  = 1'b0;
    wb_we_d     = wb_we;
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;
    case (state_q)
      MemIdle: begin
        if (in_valid) begin
          addr_lo_d  = in_alu_out[1:0];
          func3_d    = in_func3;
          is_store_d = in_is_store;
          reg_we_d   = in_reg_we;
          wb_rd_d    = in_rd;
          if (!(in_is_load || in_is_store)) begin
            wb_valid_d = 1'b1;
            wb_we_d    = in_reg_we;
            wb_data_d  = in_csr_rd ? in_csr_data : in_alu_out;
          end else if (is_misaligned(in_func3, in_alu_out[1:0])) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            misalign_d = 1'b1;
          end else begin
            state_d     = MemReq;
            mem_req_d   = 1'b1;
            mem_addr_d  = {in_alu_out[AWIDTH-1:2], 2'b00};
            // A store wins when both load and store are flagged.
            mem_we_d    = in_is_store ? st_we : 4'b0000;
            mem_wdata_d = st_wdata;
          end
        end
      end
      MemReq: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 4'b0000;
          if (is_store_q) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            state_d    = MemIdle;
          end else begin
            state_d = MemWait;
          end
        end
      end
      MemWait: begin
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = reg_we_q;
          wb_data_d  = load_val;
          state_d    = MemIdle;
        end
      end
      default: state_d = MemIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MemIdle;
      addr_lo_q  <= 2'b00;
      func3_q    <= 3'b000;
      is_store_q <= 1'b0;
      reg_we_q   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      misalign   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      func3_q    <= func3_d;
      is_store_q <= is_store_d;
      reg_we_q   <= reg_we_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      wb_valid   <= wb_valid_d;
      wb_we      <= wb_we_d;
      wb_rd      <= wb_rd_d;
      wb_data    <= wb_data_d;
      misalign   <= misalign_d;
    end
  end

endmodule
